rect_plotter: RTL and testbench
===============================

# rect_plotter

Parametrised rectangle rasteriser for the VGA adapter path. One `go` request draws a single rectangle with a solid or spike-tooth fill. Each request supplies its own origin, size and colours. The block emits one pixel per clock on registered `out_x`/`out_y`/`out_colour`/`plot`, then pulses `done`. Obstacle sprites (spikes, platforms) and erase passes use it, driven by the game control FSM.

## Interface
- `X_W`, 8: x coordinate width.
- `Y_W`, 8: y coordinate width; also the width of the height field.
- `COLOUR_W`, 3: colour width.
- `SCREEN_W`, 160: pixels with x ≥ SCREEN_W are clipped.
- `TOOTH_W`, 8: spike tooth period in pixels, ≥2.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request, sampled only in IDLE.
- `abort`  in  1  synchronous cancel while busy.
- `mode`  in  1  0 = solid, 1 = spikes.
- `org_x`  in  X_W  left edge.
- `org_y`  in  Y_W  top edge.
- `rect_w`  in  X_W  width in pixels.
- `rect_h`  in  Y_W  height in pixels.
- `fg_colour`  in  COLOUR_W  foreground colour.
- `bg_colour`  in  COLOUR_W  background colour.
- `out_x`  out  X_W  pixel x.
- `out_y`  out  Y_W  pixel y.
- `out_colour`  out  COLOUR_W  pixel colour.
- `plot`  out  1  pixel valid.
- `busy`  out  1  high in DRAW.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, DRAW, DONE.
  - IDLE→DRAW on `go` when w≠0 and h≠0.
  - IDLE→DONE on `go` when w=0 or h=0; no pixels are plotted.
  - DRAW→DONE after the last pixel.
  - DRAW→IDLE on `abort`, with no `done`.
  - DONE→IDLE unconditionally.
- On the accepting edge, all geometry, colour and mode inputs are latched. Input changes during DRAW are ignored.
- Scan order is row-major from (0,0): dx increments each cycle; at dx=w−1, dx clears and dy increments. The last pixel is (w−1, h−1).
- Pixel position: out_x = org_x + dx and out_y = org_y + dy, computed modulo 2^X_W and 2^Y_W (wrap, no saturation).
- Clipping: `plot`=0 for any pixel whose unwrapped x sum (X_W+1 bits) ≥ SCREEN_W. The scan still advances one pixel per cycle.
- Solid mode: every pixel is fg_colour.
- Spike mode:
  - p = dx mod TOOTH_W, tracked by a wrapping phase counter that resets at each row start. No divider.
  - tri = min(p, TOOTH_W−1−p).
  - The pixel is fg_colour iff dy + tri ≥ h−1 (Y_W+1-bit compare); otherwise it is bg_colour.
  - Every unclipped pixel is plotted, so the background is painted too.
- `go` asserted while busy or in DONE is ignored, not queued.
- `abort` in IDLE or DONE has no effect. `abort` and last pixel in the same cycle: abort wins, with no `done` and no pixel.

## Timing
- Reset values (async on `resetn`=0): state IDLE, out_x=0, out_y=0, out_colour=0, plot=0, busy=0, done=0, all latches and counters 0.
- All outputs are registered.
- `go` sampled at edge E0: the first pixel is valid after E1 (one cycle latency). `busy` rises after E0.
- A w×h rectangle occupies exactly w·h consecutive DRAW cycles. `done` is high for exactly the cycle after the last pixel. `busy` and `plot` are low during `done`.
- The earliest new `go` is accepted on the edge ending the `done` cycle. Back-to-back rectangles therefore cost w·h+2 cycles each.
- Zero-size request: `done` is high the cycle after E0; `plot` is never asserted.
- `abort` sampled at edge Ea: plot, busy = 0 after Ea.
- Reset mid-DRAW: outputs drop immediately (asynchronous). No `done`.

## Structure
- `rect_plotter_pkg`: state enum (IDLE/DRAW/DONE), mode constants MODE_SOLID/MODE_SPIKE, default colour constants (spike magenta 3'b101, background 3'b000).
- One sub-module, `spike_shader`: registered tooth-phase counter plus the tri/compare logic. It outputs the fg/bg select given dx-advance, row-start, dy and h.
- The top level holds the FSM, request latches, dx/dy counters, address adders and clip compare.

## Test plan
- Solid 4×3 at (10,20), fg=3'b101: plot high for 12 cycles, pixels (10..13, 20..22) row-major, `done` on cycle 13 after go, busy low after.
- Spike, TOOTH_W=8, w=16, h=4: row 3 all fg; row 0 fg only at dx∈{3,4,11,12}; every other pixel is bg_colour with plot=1.
- Clip: org_x=158, w=4, h=1: four scan cycles; plot=1 for x=158,159 and plot=0 for the next two cycles; `done` follows.
- Zero size: w=0, h=5: no plot, `done` high one cycle after go. Then an immediate second go with 1×1 draws exactly one pixel.
- Abort at pixel 5 of a 10×10 solid, with go held high throughout: plot/busy low next cycle, no `done`. A new rectangle starts on the following go, with latches reloaded.
- Async reset asserted mid-row: all outputs 0 without a clock edge; after release, go draws a fresh rectangle from (0,0) offset.

Source files
------------

// File: rtl/rect_plotter_pkg.sv
// Shared types and constants for the rectangle rasteriser: FSM states,
// fill modes and the default sprite colours used by the game controller.
package rect_plotter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SOLID = 1'b0;
  localparam logic MODE_SPIKE = 1'b1;

  localparam logic [2:0] SPIKE_COLOUR = 3'b101;
  localparam logic [2:0] BG_COLOUR    = 3'b000;

endpackage

// File: rtl/rect_plotter_if.sv
// Request/pixel bundle between the game control FSM (master) and the
// rectangle rasteriser (slave).
interface rect_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
) ();

  logic                go;
  logic                abort;
  logic                mode;
  logic [X_W-1:0]      org_x;
  logic [Y_W-1:0]      org_y;
  logic [X_W-1:0]      rect_w;
  logic [Y_W-1:0]      rect_h;
  logic [COLOUR_W-1:0] fg_colour;
  logic [COLOUR_W-1:0] bg_colour;
  logic [X_W-1:0]      out_x;
  logic [Y_W-1:0]      out_y;
  logic [COLOUR_W-1:0] out_colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output go, abort, mode, org_x, org_y, rect_w, rect_h, fg_colour, bg_colour,
    input  out_x, out_y, out_colour, plot, busy, done
  );

  modport slave (
    input  go, abort, mode, org_x, org_y, rect_w, rect_h, fg_colour, bg_colour,
    output out_x, out_y, out_colour, plot, busy, done
  );

endinterface

// File: rtl/rect_plotter_spike_shader.sv
// Spike-tooth shading: a wrapping tooth-phase counter tracks dx mod TOOTH_W
// without a divider and selects fg where dy + tooth height reaches the base row.
module spike_shader #(
  parameter int Y_W     = 8,
  parameter int TOOTH_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  input  logic           adv_i,
  input  logic [Y_W-1:0] dy_i,
  input  logic [Y_W-1:0] h_i,
  output logic           fg_sel_o
);

  localparam int P_W = (TOOTH_W > 2) ? $clog2(TOOTH_W) : 1;
  localparam logic [P_W-1:0] P_MAX = P_W'(TOOTH_W - 1);
  localparam logic [P_W-1:0] P_ONE = P_W'(1);
  localparam logic [Y_W:0]   Y_ONE = (Y_W + 1)'(1);

  logic [P_W-1:0] phase_q, phase_d;
  logic [P_W-1:0] mirror, tri_v;
  logic [Y_W:0]   lhs, rhs;

  always_comb begin
    phase_d = phase_q;
    if (clear_i)
      phase_d = '0;
    else if (adv_i)
      phase_d = (phase_q == P_MAX) ? '0 : phase_q + P_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  // Tooth height rises then falls across the period; widen before comparing so h-1 never wraps.
  always_comb begin
    mirror   = P_MAX - phase_q;
    tri_v    = (phase_q < mirror) ? phase_q : mirror;
    lhs      = {1'b0, dy_i} + (Y_W + 1)'(tri_v);
    rhs      = {1'b0, h_i} - Y_ONE;
    fg_sel_o = (lhs >= rhs);
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: latches one request, scans it row-major at one pixel
// per clock with x clipping and optional spike fill, then pulses done.
module rect_plotter
  import rect_plotter_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int TOOTH_W  = 8
) (
  input  logic          clock,
  input  logic          resetn,
  rect_plotter_if.slave bus
);

  localparam int X1_W = X_W + 1;
  localparam logic [X_W:0]   SCREEN_LIM = X1_W'(SCREEN_W);
  localparam logic [X_W-1:0] X_ONE      = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE      = Y_W'(1);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [X_W-1:0]      org_x_q, org_x_d, w_q, w_d, dx_q, dx_d, out_x_q, out_x_d;
  logic [Y_W-1:0]      org_y_q, org_y_d, h_q, h_d, dy_q, dy_d, out_y_q, out_y_d;
  logic [COLOUR_W-1:0] fg_q, fg_d, bg_q, bg_d, colour_q, colour_d;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [X_W:0] sum_x;
  logic         row_end, last_row, accept, fg_sel;

  assign sum_x    = {1'b0, org_x_q} + {1'b0, dx_q};
  assign row_end  = (dx_q == w_q - X_ONE);
  assign last_row = (dy_q == h_q - Y_ONE);
  assign accept   = (state_q == IDLE) && bus.go;

  spike_shader #(
    .Y_W     (Y_W),
    .TOOTH_W (TOOTH_W)
  ) u_shader (
    .clk      (clock),
    .rst_n    (resetn),
    .clear_i  (accept || (state_q == DRAW && row_end)),
    .adv_i    (state_q == DRAW && !row_end),
    .dy_i     (dy_q),
    .h_i      (h_q),
    .fg_sel_o (fg_sel)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    org_x_d  = org_x_q;
    org_y_d  = org_y_q;
    w_d      = w_q;
    h_d      = h_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    out_x_d  = out_x_q;
    out_y_d  = out_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          mode_d  = bus.mode;
          org_x_d = bus.org_x;
          org_y_d = bus.org_y;
          w_d     = bus.rect_w;
          h_d     = bus.rect_h;
          fg_d    = bus.fg_colour;
          bg_d    = bus.bg_colour;
          dx_d    = '0;
          dy_d    = '0;
          state_d = (bus.rect_w == '0 || bus.rect_h == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        // Abort suppresses the pixel being emitted, including the last one.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          out_x_d  = sum_x[X_W-1:0];
          out_y_d  = org_y_q + dy_q;
          colour_d = (mode_q == MODE_SPIKE && !fg_sel) ? bg_q : fg_q;
          plot_d   = (sum_x < SCREEN_LIM);
          if (row_end) begin
            dx_d = '0;
            if (last_row) state_d = DONE;
            else          dy_d    = dy_q + Y_ONE;
          end else begin
            dx_d = dx_q + X_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRAW);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      org_x_q  <= '0;
      org_y_q  <= '0;
      w_q      <= '0;
      h_q      <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      out_x_q  <= '0;
      out_y_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      out_x_q  <= out_x_d;
      out_y_q  <= out_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_colour = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: solid, spike, clip, zero-size, abort and
// asynchronous reset scenarios with hand-derived expected pixels.
module tb_rect_plotter;
  import rect_plotter_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   dx, dy, p, t, expc;

  rect_plotter_if #(.X_W(8), .Y_W(8), .COLOUR_W(3)) bus ();

  rect_plotter #(
    .X_W(8), .Y_W(8), .COLOUR_W(3), .SCREEN_W(160), .TOOTH_W(8)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic m, input int x, input int y, input int w, input int h,
                       input int fg, input int bg);
    bus.mode      = m;
    bus.org_x     = 8'(x);
    bus.org_y     = 8'(y);
    bus.rect_w    = 8'(w);
    bus.rect_h    = 8'(h);
    bus.fg_colour = 3'(fg);
    bus.bg_colour = 3'(bg);
  endtask

  initial begin
    bus.go = 1'b0;
    bus.abort = 1'b0;
    setup(MODE_SOLID, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    tick();
    check("rst plot", bus.plot, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst x", bus.out_x, 0);
    check("rst y", bus.out_y, 0);
    check("rst colour", bus.out_colour, 0);
    resetn = 1'b1;
    tick();

    // Solid 4x3 at (10,20); inputs scrambled during DRAW must be ignored
    setup(MODE_SOLID, 10, 20, 4, 3, SPIKE_COLOUR, BG_COLOUR);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    setup(MODE_SPIKE, 99, 99, 1, 1, 2, 7);
    check("s1 busy0", bus.busy, 1);
    check("s1 plot0", bus.plot, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("s1 plot%0d", i), bus.plot, 1);
      check($sformatf("s1 x%0d", i), bus.out_x, 10 + i % 4);
      check($sformatf("s1 y%0d", i), bus.out_y, 20 + i / 4);
      check($sformatf("s1 col%0d", i), bus.out_colour, 5);
      check($sformatf("s1 busy%0d", i), bus.busy, (i < 11) ? 1 : 0);
      check($sformatf("s1 done%0d", i), bus.done, 0);
    end
    tick();
    check("s1 done", bus.done, 1);
    check("s1 done plot", bus.plot, 0);
    check("s1 done busy", bus.busy, 0);
    tick();
    check("s1 done low", bus.done, 0);

    // Spike 16x4, bg painted with colour 2
    setup(MODE_SPIKE, 0, 50, 16, 4, 5, 2);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      dx = i % 16;
      dy = i / 16;
      p = dx % 8;
      t = (p < 7 - p) ? p : 7 - p;
      expc = (dy + t >= 3) ? 5 : 2;
      check($sformatf("sp col%0d", i), bus.out_colour, expc);
      check($sformatf("sp plot%0d", i), bus.plot, 1);
    end
    tick();
    check("sp done", bus.done, 1);
    tick();

    // Clip at the right screen edge
    setup(MODE_SOLID, 158, 7, 4, 1, 3, 0);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    check("clip plot0", bus.plot, 1);
    check("clip x0", bus.out_x, 158);
    tick();
    check("clip plot1", bus.plot, 1);
    check("clip x1", bus.out_x, 159);
    tick();
    check("clip plot2", bus.plot, 0);
    tick();
    check("clip plot3", bus.plot, 0);
    tick();
    check("clip done", bus.done, 1);
    tick();

    // Zero size, then an immediate 1x1 with go held high
    setup(MODE_SOLID, 0, 0, 0, 5, 1, 0);
    bus.go = 1'b1;
    tick();
    check("z busy", bus.busy, 0);
    check("z done early", bus.done, 0);
    check("z plot", bus.plot, 0);
    setup(MODE_SOLID, 5, 6, 1, 1, 6, 0);
    tick();
    check("z done", bus.done, 1);
    check("z plot2", bus.plot, 0);
    tick();
    bus.go = 1'b0;
    check("1x1 busy", bus.busy, 1);
    check("1x1 done", bus.done, 0);
    tick();
    check("1x1 plot", bus.plot, 1);
    check("1x1 x", bus.out_x, 5);
    check("1x1 y", bus.out_y, 6);
    check("1x1 col", bus.out_colour, 6);
    tick();
    check("1x1 plot off", bus.plot, 0);
    check("1x1 done2", bus.done, 1);
    tick();

    // Abort at pixel 5 of 10x10, go held high throughout
    setup(MODE_SOLID, 20, 30, 10, 10, 4, 0);
    bus.go = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ab plot%0d", i), bus.plot, 1);
      check($sformatf("ab x%0d", i), bus.out_x, 20 + i);
    end
    bus.abort = 1'b1;
    setup(MODE_SOLID, 40, 41, 3, 1, 1, 0);
    tick();
    check("ab plot off", bus.plot, 0);
    check("ab busy off", bus.busy, 0);
    check("ab no done", bus.done, 0);
    tick();
    bus.abort = 1'b0;
    bus.go = 1'b0;
    check("ab2 busy", bus.busy, 1);
    check("ab2 done", bus.done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ab2 plot%0d", i), bus.plot, 1);
      check($sformatf("ab2 x%0d", i), bus.out_x, 40 + i);
      check($sformatf("ab2 y%0d", i), bus.out_y, 41);
      check($sformatf("ab2 col%0d", i), bus.out_colour, 1);
    end
    tick();
    check("ab2 done", bus.done, 1);
    tick();

    // Asynchronous reset in the middle of a row
    setup(MODE_SOLID, 60, 70, 8, 2, 7, 0);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    check("ar pre plot", bus.plot, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar plot", bus.plot, 0);
    check("ar busy", bus.busy, 0);
    check("ar x", bus.out_x, 0);
    check("ar y", bus.out_y, 0);
    check("ar col", bus.out_colour, 0);
    check("ar done", bus.done, 0);
    tick();
    resetn = 1'b1;
    tick();
    check("ar idle done", bus.done, 0);
    setup(MODE_SOLID, 60, 70, 2, 1, 7, 0);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    check("ar2 x0", bus.out_x, 60);
    check("ar2 y0", bus.out_y, 70);
    check("ar2 plot0", bus.plot, 1);
    tick();
    check("ar2 x1", bus.out_x, 61);
    tick();
    check("ar2 done", bus.done, 1);
    check("ar2 plot off", bus.plot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
